cdc_event_arbiter: RTL

Fast-domain scheduler that shares one downstream event channel between N_REQ single-cycle event pulses, each produced by a slow-to-fast pulse synchronizer. Every requester has a saturating pending-event counter, so pulses arriving while the channel is busy are not lost. Events are issued round-robin over a valid/ready handshake, tagged with the requester index. Overflow is flagged sticky per requester.

---
 rtl/cdc_event_arbiter.sv | 82 ++++++++
 1 files changed

// File: rtl/cdc_event_arbiter.sv
// cdc_event_arbiter: round-robin scheduler sharing one valid/ready event channel between
// synchronized pulse requesters, with saturating per-requester pending counters.
module cdc_event_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 3,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_pulse_i,
  input  logic [N_REQ-1:0] req_en_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [ID_W-1:0]  evt_id_o,
  output logic [N_REQ-1:0] pend_ovf_o,
  input  logic [N_REQ-1:0] ovf_clr_i,
  output logic             busy_o
);
  typedef enum logic {IDLE, PRESENT} state_t;
  localparam logic [ID_W:0] NR = (ID_W+1)'(N_REQ);
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];
  logic [N_REQ-1:0] elig, nz, gnt_vec, ovf_q, ovf_d;
  logic [ID_W-1:0]  ptr_q, id_q, g;
  logic [ID_W:0]    s;
  logic             valid_q, found, grant;
  always_comb begin
    found = 1'b0;
    g = '0;
    s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      s = {1'b0, ptr_q} + (ID_W+1)'(k);
      s = s >= NR ? s - NR : s;
      if (!found && elig[s[ID_W-1:0]]) begin
        found = 1'b1;
        g = s[ID_W-1:0];
      end
    end
  end
  // A new grant is only possible when the channel is empty or its event is being accepted.
  assign grant   = found & (~valid_q | evt_ready_i);
  assign gnt_vec = grant ? N_REQ'(1) << g : '0;
  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    assign nz[i]    = |cnt_q[i];
    assign elig[i]  = nz[i] & req_en_i[i];
    assign cnt_d[i] = (req_pulse_i[i] & ~gnt_vec[i]) ? (&cnt_q[i] ? cnt_q[i] : cnt_q[i] + 1'b1) :
                      (~req_pulse_i[i] & gnt_vec[i]) ? cnt_q[i] - 1'b1 : cnt_q[i];
    assign ovf_d[i] = (req_pulse_i[i] & ~gnt_vec[i] & (&cnt_q[i])) | (ovf_q[i] & ~ovf_clr_i[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
      ovf_q   <= '0;
      for (int k = 0; k < N_REQ; k++) cnt_q[k] <= '0;
    end else begin
      ovf_q <= ovf_d;
      for (int k = 0; k < N_REQ; k++) cnt_q[k] <= cnt_d[k];
      if (grant) begin
        id_q  <= g;
        ptr_q <= g == ID_W'(N_REQ-1) ? '0 : g + 1'b1;
      end
      case (state_q)
        IDLE: if (found) begin
          state_q <= PRESENT;
          valid_q <= 1'b1;
        end
        PRESENT: if (evt_ready_i && !found) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end
  assign evt_valid_o = valid_q;
  assign evt_id_o    = id_q;
  assign pend_ovf_o  = ovf_q;
  assign busy_o      = valid_q | (|nz);
endmodule
